// File: rtl/data_memory_controller_pkg.sv
// data_memory_controller_pkg
// Shared definitions for the SDRAM data-memory controller:
//   - controller FSM state encoding
//   - SDRAM command encodings {cs_n, ras_n, cas_n, we_n}
//   - mode-register values (burst length 1, sequential, CL2/CL3)
//   - CPU word-address field positions (column / bank / row)
package data_memory_controller_pkg;

  typedef enum logic [3:0] {
    INIT_WAIT,
    INIT_PRE,
    INIT_REF1,
    INIT_REF2,
    INIT_MRS,
    IDLE,
    ACTIVATE,
    WRITE,
    READ,
    REFRESH
  } state_t;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_MRS   = 4'b0000;

  // Mode register: burst length 1, sequential, CAS latency in A6..A4
  localparam logic [11:0] MODE_CL2 = 12'h020;
  localparam logic [11:0] MODE_CL3 = 12'h030;

  // CPU word-address fields
  localparam int COL_LSB  = 0;
  localparam int COL_MSB  = 8;
  localparam int BANK_LSB = 9;
  localparam int BANK_MSB = 10;
  localparam int ROW_LSB  = 11;
  localparam int ROW_MSB  = 19;

  // A10: all-banks on PRE, auto-precharge on READ/WRITE
  localparam int AP_BIT = 10;

  function automatic logic [11:0] mode_reg_value(input int cas_latency);
    return (cas_latency == 2) ? MODE_CL2 : MODE_CL3;
  endfunction

endpackage

// File: rtl/data_memory_controller_timer.sv
// sdram_cmd_timer
// Loadable down-counter that times every NOP interval of the controller.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   load        load load_value this cycle (takes priority over counting)
//   load_value  new count
//   count       current count value
//   done        high while count is zero
// The count sits at RESET_COUNT after reset so the power-up wait starts
// without an explicit load.
module sdram_cmd_timer #(
  parameter int                WIDTH       = 16,
  parameter logic [WIDTH-1:0]  RESET_COUNT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             done
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= RESET_COUNT;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign count = count_reg;
  assign done  = (count_reg == '0);

endmodule

// File: rtl/data_memory_controller.sv
// data_memory_controller
// Single-port data-memory controller: converts one-word CPU read/write
// strobes into SDR SDRAM command sequences for a 32-bit bus made of two x16
// devices sharing address, bank, command and DQM lines. Runs the power-up
// init sequence (NOP wait, PRE all, REF, REF, MRS) and keeps bus_busy high
// while initialising or servicing a request.
//
// Optional feature: define DATA_MEMORY_CONTROLLER_REFRESH_EN to enable the
// periodic auto-refresh (one REF every REFRESH_INTERVAL cycles, served from
// IDLE ahead of new requests). Without it no refresh is issued after init.
//
// Ports:
//   clk, rst                  system clock, asynchronous active-high reset
//   data_rd_en, data_wr_en    one-cycle request strobes (write wins)
//   data_addr, data_in        word address / write data, latched on accept
//   data_out                  last read data, held until the next read
//   bus_busy                  high while initialising or busy
//   dram_dq_in, dram_dq_out   SDRAM data in / out
//   dram_addr, dram_ba        SDRAM row/column/mode address, bank
//   dram_dqm                  byte masks, active-high
//   dram_*_n                  command lines
//   dram_clk, dram_cke        SDRAM clock (~clk), clock enable
//
// All SDRAM pins are registered, so a command appears on the pins one cycle
// after the FSM state that decides it.
module data_memory_controller
  import data_memory_controller_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDR_WIDTH       = 20,
  parameter int SDRAM_DATA_WIDTH = 32,
  parameter int SDRAM_ADDR_WIDTH = 20,
  parameter int SDRAM_DQM_WIDTH  = 4,
  parameter int SDRAM_BA_WIDTH   = 2,
  parameter int INIT_CYCLES      = 10000,
  parameter int CAS_LATENCY      = 3,
  parameter int T_RP             = 2,
  parameter int T_RCD            = 2,
  parameter int T_RC             = 7,
  parameter int T_MRD            = 2,
  parameter int T_WR             = 2,
  parameter int REFRESH_INTERVAL = 750
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        data_rd_en,
  input  logic                        data_wr_en,
  input  logic [ADDR_WIDTH-1:0]       data_addr,
  input  logic [DATA_WIDTH-1:0]       data_in,
  output logic [DATA_WIDTH-1:0]       data_out,
  output logic                        bus_busy,
  input  logic [SDRAM_DATA_WIDTH-1:0] dram_dq_in,
  output logic [SDRAM_DATA_WIDTH-1:0] dram_dq_out,
  output logic [SDRAM_ADDR_WIDTH-1:0] dram_addr,
  output logic [SDRAM_DQM_WIDTH-1:0]  dram_dqm,
  output logic                        dram_we_n,
  output logic                        dram_cas_n,
  output logic                        dram_ras_n,
  output logic                        dram_cs_n,
  output logic [SDRAM_BA_WIDTH-1:0]   dram_ba,
  output logic                        dram_clk,
  output logic                        dram_cke
);

  // Parameter sanity checks, resolved at elaboration.
  if (DATA_WIDTH != SDRAM_DATA_WIDTH) begin : g_bad_width
    $error("DATA_WIDTH must equal SDRAM_DATA_WIDTH");
  end
  if (CAS_LATENCY != 2 && CAS_LATENCY != 3) begin : g_bad_cl
    $error("CAS_LATENCY must be 2 or 3");
  end
  if (REFRESH_INTERVAL < 2) begin : g_bad_refresh
    $error("REFRESH_INTERVAL must be at least 2");
  end

  localparam int TW = $clog2(INIT_CYCLES + CAS_LATENCY + T_RP + T_RCD + T_RC +
                             T_MRD + T_WR + 2);
  // READ wait: CAS_LATENCY+1 cycles to the capture edge, then T_RP NOPs.
  localparam int READ_WAIT = CAS_LATENCY + T_RP;

  state_t state_reg, state_next;
  logic   in_wait_reg, in_wait_next;   // 0: command cycle, 1: NOP interval

  logic          timer_load;
  logic [TW-1:0] timer_value;
  logic [TW-1:0] timer_count;
  logic          timer_done;

  logic                  op_write_reg;
  logic [ADDR_WIDTH-1:0] addr_lat_reg;
  logic [DATA_WIDTH-1:0] data_lat_reg;
  logic [DATA_WIDTH-1:0] data_out_reg;

  logic [3:0]                  cmd_reg, cmd_next;
  logic [SDRAM_ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [SDRAM_BA_WIDTH-1:0]   ba_reg, ba_next;
  logic [SDRAM_DQM_WIDTH-1:0]  dqm_reg, dqm_next;
  logic [SDRAM_DATA_WIDTH-1:0] dq_out_reg, dq_out_next;
  logic                        cke_reg;

  // Generic "issue command, then wait" step used by every command state
  logic          step_en;
  logic [3:0]    step_cmd;
  logic [TW-1:0] step_wait;
  state_t        step_after;

  logic accept;
  logic read_capture;
  logic refresh_due;
  logic init_done;

  sdram_cmd_timer #(
    .WIDTH       (TW),
    .RESET_COUNT (TW'(INIT_CYCLES - 1))
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (timer_value),
    .count      (timer_count),
    .done       (timer_done)
  );

  assign init_done    = (state_reg == IDLE) || (state_reg == ACTIVATE) ||
                        (state_reg == WRITE) || (state_reg == READ) ||
                        (state_reg == REFRESH);
  assign accept       = (state_reg == IDLE) && !refresh_due &&
                        (data_wr_en || data_rd_en);
  // Count equals T_RP exactly CAS_LATENCY+1 cycles after READ is on the pins.
  assign read_capture = (state_reg == READ) && in_wait_reg &&
                        (timer_count == TW'(T_RP));

`ifdef DATA_MEMORY_CONTROLLER_REFRESH_EN
  localparam int RW = $clog2(REFRESH_INTERVAL + 1);

  logic [RW-1:0] refresh_cnt_reg;
  logic          refresh_pending_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt_reg     <= '0;
      refresh_pending_reg <= 1'b0;
    end else if (init_done) begin
      if (refresh_cnt_reg == RW'(REFRESH_INTERVAL - 1)) begin
        refresh_cnt_reg     <= '0;
        refresh_pending_reg <= 1'b1;
      end else begin
        refresh_cnt_reg <= refresh_cnt_reg + 1'b1;
        if ((state_reg == IDLE) && refresh_pending_reg) begin
          refresh_pending_reg <= 1'b0;
        end
      end
    end
  end

  assign refresh_due = refresh_pending_reg;
`else
  assign refresh_due = 1'b0;
`endif

  always_comb begin
    state_next   = state_reg;
    in_wait_next = in_wait_reg;
    timer_load   = 1'b0;
    timer_value  = '0;
    cmd_next     = CMD_NOP;
    addr_next    = '0;
    ba_next      = '0;
    dqm_next     = '1;
    dq_out_next  = '0;
    step_en      = 1'b0;
    step_cmd     = CMD_NOP;
    step_wait    = '0;
    step_after   = IDLE;

    case (state_reg)
      INIT_WAIT: begin
        if (timer_done) begin
          state_next   = INIT_PRE;
          in_wait_next = 1'b0;
        end
      end
      INIT_PRE: begin
        step_en    = 1'b1;
        step_cmd   = CMD_PRE;
        step_wait  = TW'(T_RP - 1);
        step_after = INIT_REF1;
        if (!in_wait_reg) addr_next[AP_BIT] = 1'b1;
      end
      INIT_REF1: begin
        step_en    = 1'b1;
        step_cmd   = CMD_REF;
        step_wait  = TW'(T_RC - 1);
        step_after = INIT_REF2;
      end
      INIT_REF2: begin
        step_en    = 1'b1;
        step_cmd   = CMD_REF;
        step_wait  = TW'(T_RC - 1);
        step_after = INIT_MRS;
      end
      INIT_MRS: begin
        step_en    = 1'b1;
        step_cmd   = CMD_MRS;
        step_wait  = TW'(T_MRD - 1);
        step_after = IDLE;
        if (!in_wait_reg) addr_next = SDRAM_ADDR_WIDTH'(mode_reg_value(CAS_LATENCY));
      end
      IDLE: begin
        in_wait_next = 1'b0;
        if (refresh_due) begin
          state_next = REFRESH;
        end else if (accept) begin
          state_next = ACTIVATE;
        end
      end
      ACTIVATE: begin
        step_en    = 1'b1;
        step_cmd   = CMD_ACT;
        step_wait  = TW'(T_RCD - 1);
        step_after = op_write_reg ? WRITE : READ;
        if (!in_wait_reg) begin
          addr_next = SDRAM_ADDR_WIDTH'(addr_lat_reg[ROW_MSB:ROW_LSB]);
          ba_next   = addr_lat_reg[BANK_MSB:BANK_LSB];
        end
      end
      WRITE: begin
        step_en    = 1'b1;
        step_cmd   = CMD_WRITE;
        step_wait  = TW'(T_WR + T_RP - 1);
        step_after = IDLE;
        if (!in_wait_reg) begin
          addr_next         = SDRAM_ADDR_WIDTH'(addr_lat_reg[COL_MSB:COL_LSB]);
          addr_next[AP_BIT] = 1'b1;
          ba_next           = addr_lat_reg[BANK_MSB:BANK_LSB];
          dqm_next          = '0;
          dq_out_next       = SDRAM_DATA_WIDTH'(data_lat_reg);
        end
      end
      READ: begin
        step_en    = 1'b1;
        step_cmd   = CMD_READ;
        step_wait  = TW'(READ_WAIT);
        step_after = IDLE;
        if (!in_wait_reg) begin
          addr_next         = SDRAM_ADDR_WIDTH'(addr_lat_reg[COL_MSB:COL_LSB]);
          addr_next[AP_BIT] = 1'b1;
          ba_next           = addr_lat_reg[BANK_MSB:BANK_LSB];
          dqm_next          = '0;
        end else if (timer_count == TW'(READ_WAIT)) begin
          // keep DQM low for the cycle after READ as well
          dqm_next = '0;
        end
      end
      REFRESH: begin
        step_en    = 1'b1;
        step_cmd   = CMD_REF;
        step_wait  = TW'(T_RC - 1);
        step_after = IDLE;
      end
      default: begin
        state_next   = INIT_WAIT;
        in_wait_next = 1'b1;
        timer_load   = 1'b1;
        timer_value  = TW'(INIT_CYCLES - 1);
      end
    endcase

    if (step_en) begin
      if (!in_wait_reg) begin
        cmd_next     = step_cmd;
        timer_load   = 1'b1;
        timer_value  = step_wait;
        in_wait_next = 1'b1;
      end else if (timer_done) begin
        state_next   = step_after;
        in_wait_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= INIT_WAIT;
      in_wait_reg <= 1'b1;
      cmd_reg     <= CMD_NOP;
      addr_reg    <= '0;
      ba_reg      <= '0;
      dqm_reg     <= '1;
      dq_out_reg  <= '0;
      cke_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      in_wait_reg <= in_wait_next;
      cmd_reg     <= cmd_next;
      addr_reg    <= addr_next;
      ba_reg      <= ba_next;
      dqm_reg     <= dqm_next;
      dq_out_reg  <= dq_out_next;
      cke_reg     <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_write_reg <= 1'b0;
      addr_lat_reg <= '0;
      data_lat_reg <= '0;
      data_out_reg <= '0;
    end else begin
      if (accept) begin
        op_write_reg <= data_wr_en;
        addr_lat_reg <= data_addr;
        data_lat_reg <= data_in;
      end
      if (read_capture) begin
        data_out_reg <= DATA_WIDTH'(dram_dq_in);
      end
    end
  end

  assign bus_busy    = (state_reg != IDLE);
  assign data_out    = data_out_reg;
  assign dram_dq_out = dq_out_reg;
  assign dram_addr   = addr_reg;
  assign dram_ba     = ba_reg;
  assign dram_dqm    = dqm_reg;
  assign dram_cs_n   = cmd_reg[3];
  assign dram_ras_n  = cmd_reg[2];
  assign dram_cas_n  = cmd_reg[1];
  assign dram_we_n   = cmd_reg[0];
  assign dram_cke    = cke_reg;
  assign dram_clk    = ~clk;

endmodule

// File: tb/tb_data_memory_controller.sv
// tb_data_memory_controller
// Directed bench for data_memory_controller with a small SDRAM model that
// records commands, stores written words and returns read data only in the
// single cycle in which the controller is supposed to capture it.
module tb_data_memory_controller;

  localparam int INIT = 100;
  localparam int CL   = 3;
  localparam int TRP  = 2;
  localparam int TRCD = 2;
  localparam int TRC  = 7;
  localparam int TMRD = 2;
  localparam int TWR  = 2;

  localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101,
                         WR = 4'b0100, PRE = 4'b0010, REF = 4'b0001,
                         MRS = 4'b0000;

  // 788  -> row 0, bank 1, column 276 ; with A10 = 0x514
  // 1985 -> row 0, bank 3, column 449 ; with A10 = 0x5C1
  localparam logic [19:0] A788_CA  = 20'h00514;
  localparam logic [19:0] A1985_CA = 20'h005C1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_rd_en = 1'b0;
  logic        data_wr_en = 1'b0;
  logic [19:0] data_addr = '0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        bus_busy;
  logic [31:0] dram_dq_in = 32'hDEADBEEF;
  logic [31:0] dram_dq_out;
  logic [19:0] dram_addr;
  logic [3:0]  dram_dqm;
  logic        dram_we_n, dram_cas_n, dram_ras_n, dram_cs_n;
  logic [1:0]  dram_ba;
  logic        dram_clk, dram_cke;

  always #5 clk = ~clk;

  data_memory_controller #(.INIT_CYCLES(INIT)) dut (
    .clk(clk), .rst(rst), .data_rd_en(data_rd_en), .data_wr_en(data_wr_en),
    .data_addr(data_addr), .data_in(data_in), .data_out(data_out),
    .bus_busy(bus_busy), .dram_dq_in(dram_dq_in), .dram_dq_out(dram_dq_out),
    .dram_addr(dram_addr), .dram_dqm(dram_dqm), .dram_we_n(dram_we_n),
    .dram_cas_n(dram_cas_n), .dram_ras_n(dram_ras_n), .dram_cs_n(dram_cs_n),
    .dram_ba(dram_ba), .dram_clk(dram_clk), .dram_cke(dram_cke)
  );

  typedef struct {
    logic [3:0]  cmd;
    logic [19:0] addr;
    logic [1:0]  ba;
    logic [3:0]  dqm;
    logic [31:0] dq;
    int          cyc;
  } ev_t;

  ev_t         ev_q[$];
  int          cyc = 0;
  int          dqm_low_cnt = 0;
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [8:0]  act_row [4];
  logic [31:0] mem [int];
  int          rd_due = -1;
  logic [31:0] rd_data = '0;

  wire [3:0] cmd = {dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n};

  always @(posedge clk) cyc <= cyc + 1;

  // SDRAM model, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      rd_due     = -1;
      dram_dq_in = 32'hDEADBEEF;
    end else begin
      if (dram_dqm != 4'hF) dqm_low_cnt++;
      if (cmd != NOP) ev_q.push_back(ev_t'{cmd, dram_addr, dram_ba, dram_dqm, dram_dq_out, cyc});
      if (cmd == ACT) act_row[dram_ba] = dram_addr[8:0];
      if (cmd == WR && dram_dqm == 4'h0)
        mem[int'({act_row[dram_ba], dram_ba, dram_addr[8:0]})] = dram_dq_out;
      if (cmd == RD) begin
        rd_due  = cyc + CL;
        rd_data = mem.exists(int'({act_row[dram_ba], dram_ba, dram_addr[8:0]})) ?
                  mem[int'({act_row[dram_ba], dram_ba, dram_addr[8:0]})] : 32'h0BAD0BAD;
      end
      dram_dq_in = (cyc == rd_due) ? rd_data : 32'hDEADBEEF;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic ev_t get_ev(input int i);
    ev_t e;
    e = ev_t'{4'b1111, 20'hFFFFF, 2'b11, 4'hF, 32'hFFFFFFFF, -1000};
    if (i < ev_q.size()) e = ev_q[i];
    return e;
  endfunction

  function automatic int count_cmd(input logic [3:0] c);
    int n = 0;
    foreach (ev_q[i]) if (ev_q[i].cmd == c) n++;
    return n;
  endfunction

  // Bounded wait for bus_busy low; returns -1 if it never falls.
  task automatic wait_idle(input int limit, output int fall_cyc);
    fall_cyc = -1;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (!bus_busy) begin
        fall_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic issue(input logic wr, input logic rd, input logic [19:0] a, input logic [31:0] d);
    @(negedge clk);
    data_wr_en = wr; data_rd_en = rd; data_addr = a; data_in = d;
    @(negedge clk);
    data_wr_en = 1'b0; data_rd_en = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    tests_run++; if (bus_busy !== 1'b1) begin tests_failed++; $display("FAIL %s_busy got=%b exp=1", tag, bus_busy); end
    tests_run++; if (cmd !== NOP) begin tests_failed++; $display("FAIL %s_cmd got=%b exp=0111", tag, cmd); end
    tests_run++; if (dram_cke !== 1'b0) begin tests_failed++; $display("FAIL %s_cke got=%b exp=0", tag, dram_cke); end
    tests_run++; if (dram_dqm !== 4'hF) begin tests_failed++; $display("FAIL %s_dqm got=%h exp=f", tag, dram_dqm); end
    tests_run++; if (dram_addr !== 20'h0 || dram_ba !== 2'b0) begin tests_failed++; $display("FAIL %s_addr got=%h/%h exp=0/0", tag, dram_addr, dram_ba); end
    tests_run++; if (dram_dq_out !== 32'h0) begin tests_failed++; $display("FAIL %s_dq_out got=%h exp=0", tag, dram_dq_out); end
    tests_run++; if (data_out !== 32'h0) begin tests_failed++; $display("FAIL %s_data_out got=%h exp=0", tag, data_out); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    $display("[TB] reset: outputs checked");
  endtask

  // Releases reset and checks the complete init sequence.
  task automatic test_init();
    int rel, fall;
    ev_t e;
    ev_q.delete();
    @(negedge clk);
    rst = 1'b0;
    rel = cyc;
    @(negedge clk);
    tests_run++; if (dram_cke !== 1'b1) begin tests_failed++; $display("FAIL init_cke got=%b exp=1", dram_cke); end
    tests_run++; if (bus_busy !== 1'b1) begin tests_failed++; $display("FAIL init_busy got=%b exp=1", bus_busy); end
    wait_idle(INIT + 200, fall);
    tests_run++; if (ev_q.size() !== 4) begin tests_failed++; $display("FAIL init_count got=%0d exp=4", ev_q.size()); end
    e = get_ev(0);
    tests_run++; if (e.cmd !== PRE || e.addr[10] !== 1'b1) begin tests_failed++; $display("FAIL init_pre got=%b a10=%b exp=0010 a10=1", e.cmd, e.addr[10]); end
    tests_run++; if (e.cyc - rel < INIT) begin tests_failed++; $display("FAIL init_wait got=%0d exp>=%0d", e.cyc - rel, INIT); end
    tests_run++; if (get_ev(1).cmd !== REF || get_ev(1).cyc - e.cyc !== TRP + 1) begin tests_failed++; $display("FAIL init_ref1 got=%b gap=%0d exp=0001 gap=%0d", get_ev(1).cmd, get_ev(1).cyc - e.cyc, TRP + 1); end
    tests_run++; if (get_ev(2).cmd !== REF || get_ev(2).cyc - get_ev(1).cyc !== TRC + 1) begin tests_failed++; $display("FAIL init_ref2 got=%b gap=%0d exp=0001 gap=%0d", get_ev(2).cmd, get_ev(2).cyc - get_ev(1).cyc, TRC + 1); end
    e = get_ev(3);
    tests_run++; if (e.cmd !== MRS || e.addr !== 20'h00030 || e.cyc - get_ev(2).cyc !== TRC + 1) begin tests_failed++; $display("FAIL init_mrs got=%b addr=%h gap=%0d exp=0000 addr=00030 gap=%0d", e.cmd, e.addr, e.cyc - get_ev(2).cyc, TRC + 1); end
    tests_run++; if (fall - e.cyc !== TMRD) begin tests_failed++; $display("FAIL init_busy_fall got=%0d exp=%0d", fall - e.cyc, TMRD); end
    $display("[TB] init: %0d commands, busy fell at cycle %0d", ev_q.size(), fall);
  endtask

  task automatic test_write();
    int fall;
    ev_t e;
    ev_q.delete();
    dqm_low_cnt = 0;
    issue(1'b1, 1'b0, 20'd788, 32'hABCDEF98);
    tests_run++; if (bus_busy !== 1'b1) begin tests_failed++; $display("FAIL wr_busy_rise got=%b exp=1", bus_busy); end
    wait_idle(100, fall);
    e = get_ev(0);
    tests_run++; if (ev_q.size() !== 2) begin tests_failed++; $display("FAIL wr_count got=%0d exp=2", ev_q.size()); end
    tests_run++; if (e.cmd !== ACT || e.addr !== 20'h0 || e.ba !== 2'd1) begin tests_failed++; $display("FAIL wr_act got=%b addr=%h ba=%0d exp=0011 addr=0 ba=1", e.cmd, e.addr, e.ba); end
    e = get_ev(1);
    tests_run++; if (e.cmd !== WR || e.addr !== A788_CA || e.ba !== 2'd1) begin tests_failed++; $display("FAIL wr_cmd got=%b addr=%h ba=%0d exp=0100 addr=%h ba=1", e.cmd, e.addr, e.ba, A788_CA); end
    tests_run++; if (e.dqm !== 4'h0 || e.dq !== 32'hABCDEF98) begin tests_failed++; $display("FAIL wr_data got=dqm %h dq %h exp=dqm 0 dq abcdef98", e.dqm, e.dq); end
    tests_run++; if (dqm_low_cnt !== 1) begin tests_failed++; $display("FAIL wr_dqm_cycles got=%0d exp=1", dqm_low_cnt); end
    tests_run++; if (e.cyc - get_ev(0).cyc !== TRCD + 1) begin tests_failed++; $display("FAIL wr_trcd got=%0d exp=%0d", e.cyc - get_ev(0).cyc, TRCD + 1); end
    tests_run++; if (fall - e.cyc !== TWR + TRP) begin tests_failed++; $display("FAIL wr_busy_fall got=%0d exp=%0d", fall - e.cyc, TWR + TRP); end
    $display("[TB] write 788 <= abcdef98, busy fell at cycle %0d", fall);
  endtask

  task automatic test_read();
    int fall;
    ev_t e;
    issue(1'b1, 1'b0, 20'd1985, 32'h01234567);
    wait_idle(100, fall);
    $display("[TB] write 1985 <= 01234567, busy fell at cycle %0d", fall);
    ev_q.delete();
    dqm_low_cnt = 0;
    issue(1'b0, 1'b1, 20'd788, 32'h0);
    wait_idle(100, fall);
    e = get_ev(1);
    tests_run++; if (e.cmd !== RD || e.addr !== A788_CA || e.ba !== 2'd1) begin tests_failed++; $display("FAIL rd_cmd got=%b addr=%h ba=%0d exp=0101 addr=%h ba=1", e.cmd, e.addr, e.ba, A788_CA); end
    tests_run++; if (dqm_low_cnt !== 2) begin tests_failed++; $display("FAIL rd_dqm_cycles got=%0d exp=2", dqm_low_cnt); end
    tests_run++; if (fall - e.cyc !== CL + 1 + TRP) begin tests_failed++; $display("FAIL rd_busy_fall got=%0d exp=%0d", fall - e.cyc, CL + 1 + TRP); end
    tests_run++; if (data_out !== 32'hABCDEF98) begin tests_failed++; $display("FAIL rd_788 got=%h exp=abcdef98", data_out); end
    $display("[TB] read 788 -> %h", data_out);
    issue(1'b0, 1'b1, 20'd1985, 32'h0);
    wait_idle(100, fall);
    tests_run++; if (data_out !== 32'h01234567) begin tests_failed++; $display("FAIL rd_1985 got=%h exp=01234567", data_out); end
    $display("[TB] read 1985 -> %h", data_out);
    issue(1'b1, 1'b0, 20'd5, 32'hCAFEF00D);
    wait_idle(100, fall);
    tests_run++; if (data_out !== 32'h01234567) begin tests_failed++; $display("FAIL rd_hold got=%h exp=01234567", data_out); end
    $display("[TB] write 5 <= cafef00d, data_out held %h", data_out);
  endtask

  task automatic test_both_strobes();
    int fall;
    ev_q.delete();
    issue(1'b1, 1'b1, 20'd1985, 32'h5A5A0FF0);
    wait_idle(100, fall);
    tests_run++; if (count_cmd(RD) !== 0 || count_cmd(WR) !== 1) begin tests_failed++; $display("FAIL both_cmds got=rd %0d wr %0d exp=rd 0 wr 1", count_cmd(RD), count_cmd(WR)); end
    tests_run++; if (get_ev(1).addr !== A1985_CA || get_ev(1).ba !== 2'd3 || get_ev(1).dq !== 32'h5A5A0FF0) begin tests_failed++; $display("FAIL both_wr got=addr %h ba %0d dq %h exp=addr %h ba 3 dq 5a5a0ff0", get_ev(1).addr, get_ev(1).ba, get_ev(1).dq, A1985_CA); end
    issue(1'b0, 1'b1, 20'd1985, 32'h0);
    wait_idle(100, fall);
    tests_run++; if (data_out !== 32'h5A5A0FF0) begin tests_failed++; $display("FAIL both_readback got=%h exp=5a5a0ff0", data_out); end
    $display("[TB] rd+wr 1985 <= 5a5a0ff0, readback %h", data_out);
  endtask

  task automatic test_busy_ignore();
    int fall;
    ev_q.delete();
    issue(1'b1, 1'b0, 20'd788, 32'h13579BDF);
    data_rd_en = 1'b1; data_addr = 20'd1985;
    @(negedge clk);
    data_rd_en = 1'b0;
    wait_idle(100, fall);
    repeat (10) @(negedge clk);
    tests_run++; if (count_cmd(ACT) !== 1 || count_cmd(RD) !== 0) begin tests_failed++; $display("FAIL busy_ignore got=act %0d rd %0d exp=act 1 rd 0", count_cmd(ACT), count_cmd(RD)); end
    tests_run++; if (bus_busy !== 1'b0) begin tests_failed++; $display("FAIL busy_ignore_idle got=%b exp=0", bus_busy); end
    $display("[TB] strobe while busy: %0d ACT, %0d READ", count_cmd(ACT), count_cmd(RD));
  endtask

  task automatic test_reset_mid_read();
    int fall;
    issue(1'b0, 1'b1, 20'd1985, 32'h0);
    repeat (2) @(negedge clk);
    tests_run++; if (bus_busy !== 1'b1) begin tests_failed++; $display("FAIL midrd_busy got=%b exp=1", bus_busy); end
    rst = 1'b1;
    #1;
    check_reset_values("midrd");
    $display("[TB] reset asserted mid-read");
    repeat (2) @(negedge clk);
    test_init();
    issue(1'b0, 1'b1, 20'd788, 32'h0);
    wait_idle(100, fall);
    tests_run++; if (data_out !== 32'h13579BDF) begin tests_failed++; $display("FAIL midrd_reread got=%h exp=13579bdf", data_out); end
    $display("[TB] read 788 after re-init -> %h", data_out);
  endtask

  initial begin
    test_reset();
    test_init();
    test_write();
    test_read();
    test_both_strobes();
    test_busy_ignore();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
